// File: rtl/sfx_pkg.sv
// Shared types and timing helpers for the sound-effect scheduler.
package sfx_pkg;

  typedef enum logic [1:0] {
    SND_FIRE     = 2'd0,
    SND_HIT      = 2'd1,
    SND_EXPLODE  = 2'd2,
    SND_GAMEOVER = 2'd3
  } sound_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] NOTES_FIRE     = 32'd2;
  localparam logic [31:0] NOTES_HIT      = 32'd1;
  localparam logic [31:0] NOTES_EXPLODE  = 32'd3;
  localparam logic [31:0] NOTES_GAMEOVER = 32'd4;

  // Full playback time of a sound including the trailing silent guard.
  function automatic logic [31:0] sfx_duration(input sound_id_t id,
                                               input int unsigned note_period,
                                               input int unsigned guard);
    logic [31:0] notes;
    case (id)
      SND_FIRE:    notes = NOTES_FIRE;
      SND_HIT:     notes = NOTES_HIT;
      SND_EXPLODE: notes = NOTES_EXPLODE;
      default:     notes = NOTES_GAMEOVER;
    endcase
    return notes * (32'(note_period) + 32'd1) + 32'(guard);
  endfunction

endpackage

// File: rtl/sfx_fifo.sv
// Small synchronous FIFO of sound IDs with flush; a pop frees a slot
// for a push in the same cycle even when full.
module sfx_fifo
  import sfx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  sound_id_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output sound_id_t              head_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  sound_id_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  // Qualify requests and compute next pointers/occupancy; flush empties everything.
  always_comb begin
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != FULL_LEVEL) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: queues event pulses and triggers the tone players
// one at a time, waiting out each sound's full duration; game over pre-empts.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned NOTE_PERIOD = CLK_HZ / 20,
  parameter int unsigned GUARD       = 1000,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ev_fire,
  input  logic                   ev_hit,
  input  logic                   ev_explode,
  input  logic                   ev_gameover,
  output logic                   trig_fire,
  output logic                   trig_hit,
  output logic                   trig_explode,
  output logic                   trig_gameover,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_level,
  output logic [7:0]             drop_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  state_t      state_q, state_d;
  sound_id_t   cur_id_q, cur_id_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic [8:0]  drop_sum;
  logic [1:0]  drop_inc;
  logic [1:0]  n_normal;
  logic        fifo_push, fifo_pop, fifo_flush;
  sound_id_t   push_id, head_id;
  logic [LW-1:0] fifo_level;
  logic        go_active, go_take;

  // Game-over sound currently owns the players; a fresh game over starts one.
  assign go_active = (state_q != ST_IDLE) && (cur_id_q == SND_GAMEOVER);
  assign go_take   = ev_gameover && !go_active;
  assign n_normal  = {1'b0, ev_fire} + {1'b0, ev_hit} + {1'b0, ev_explode};

  sfx_fifo #(
    .DEPTH (int'(DEPTH))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_id),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (head_id),
    .level     (fifo_level)
  );

  // Playback FSM: pop, trigger, then hold for the sound's duration.
  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    hold_cnt_d = hold_cnt_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_level != '0) begin
          fifo_pop = 1'b1;
          cur_id_d = head_id;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        hold_cnt_d = sfx_duration(cur_id_q, NOTE_PERIOD, GUARD) - 32'd1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) state_d = ST_IDLE;
        else                  hold_cnt_d = hold_cnt_q - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_take) begin
      fifo_pop = 1'b0;
      cur_id_d = SND_GAMEOVER;
      state_d  = ST_ISSUE;
    end
  end

  // Event intake: priority-select one event, account every discarded one.
  always_comb begin
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    push_id    = SND_FIRE;
    drop_inc   = 2'd0;
    if (go_active) begin
      drop_inc = n_normal;
    end else if (ev_gameover) begin
      fifo_flush = 1'b1;
      drop_inc   = n_normal;
    end else if (n_normal != 2'd0) begin
      fifo_push = 1'b1;
      if (ev_explode)  push_id = SND_EXPLODE;
      else if (ev_hit) push_id = SND_HIT;
      else             push_id = SND_FIRE;
      if ((fifo_level != FULL_LEVEL) || fifo_pop) drop_inc = n_normal - 2'd1;
      else                                        drop_inc = n_normal;
    end
    drop_sum     = {1'b0, drop_count_q} + {7'd0, drop_inc};
    drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // State, hold counter and drop counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_id_q     <= SND_FIRE;
      hold_cnt_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      hold_cnt_q   <= hold_cnt_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign trig_fire     = (state_q == ST_ISSUE) && (cur_id_q == SND_FIRE);
  assign trig_hit      = (state_q == ST_ISSUE) && (cur_id_q == SND_HIT);
  assign trig_explode  = (state_q == ST_ISSUE) && (cur_id_q == SND_EXPLODE);
  assign trig_gameover = (state_q == ST_ISSUE) && (cur_id_q == SND_GAMEOVER);
  assign busy          = (state_q != ST_IDLE) || (fifo_level != '0);
  assign queue_level   = fifo_level;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with NOTE_PERIOD=9, GUARD=2, DEPTH=4:
// D(FIRE)=22, D(HIT)=12, D(EXPLODE)=32, D(GAMEOVER)=42.
module tb_sfx_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ev_fire = 1'b0, ev_hit = 1'b0, ev_explode = 1'b0, ev_gameover = 1'b0;
  logic       trig_fire, trig_hit, trig_explode, trig_gameover;
  logic       busy;
  logic [2:0] queue_level;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_trig [4];
  int last_cyc [4];
  int max_level;
  bit prev_any;
  int b;
  int snap;

  sfx_scheduler #(
    .NOTE_PERIOD (9),
    .GUARD       (2),
    .DEPTH       (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ev_fire       (ev_fire),
    .ev_hit        (ev_hit),
    .ev_explode    (ev_explode),
    .ev_gameover   (ev_gameover),
    .trig_fire     (trig_fire),
    .trig_hit      (trig_hit),
    .trig_explode  (trig_explode),
    .trig_gameover (trig_gameover),
    .busy          (busy),
    .queue_level   (queue_level),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Trigger monitor: records trigger cycles and checks one-hot, single-cycle pulses.
  always @(negedge clk) begin
    logic [3:0] tv;
    tv = {trig_gameover, trig_explode, trig_hit, trig_fire};
    if (tv != 4'b0) begin
      checks++;
      assert ($onehot(tv) && !prev_any) else begin
        errors++;
        $error("FAIL trig_shape: observed=%b (prev_any=%0d) expected=one-hot single-cycle", tv, prev_any);
      end
      for (int i = 0; i < 4; i++) begin
        if (tv[i]) begin
          n_trig[i]++;
          last_cyc[i] = cyc;
          $display("cycle %0d: trigger id=%0d", cyc, i);
        end
      end
    end
    prev_any = (tv != 4'b0);
    if (int'(queue_level) > max_level) max_level = int'(queue_level);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      n_trig[i]   = 0;
      last_cyc[i] = -1;
    end
    max_level = 0;
  endtask

  task automatic do_reset();
    ev_fire = 0; ev_hit = 0; ev_explode = 0; ev_gameover = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_stats();
    b = cyc;
  endtask

  function automatic int total_trigs();
    return n_trig[0] + n_trig[1] + n_trig[2] + n_trig[3];
  endfunction

  initial begin
    clear_stats();
    prev_any = 0;

    // Reset state
    do_reset();
    check("reset_trigs", {28'd0, trig_gameover, trig_explode, trig_hit, trig_fire}, 32'd0);
    check("reset_busy", busy, 0);
    check("reset_level", queue_level, 0);
    check("reset_drops", drop_count, 0);

    // Test 1: single fire
    go_to(b + 10); ev_fire = 1; tick(); ev_fire = 0;
    check("t1_level_c11", queue_level, 1);
    go_to(b + 12);
    check("t1_trig_c12", trig_fire, 1);
    go_to(b + 34);
    check("t1_busy_c34", busy, 1);
    go_to(b + 36);
    check("t1_busy_c36", busy, 0);
    go_to(b + 40);
    check("t1_fire_cycle", last_cyc[0], b + 12);
    check("t1_trig_total", total_trigs(), 1);
    check("t1_drops", drop_count, 0);

    // Test 2: fire then hit one cycle later
    do_reset();
    go_to(b + 10); ev_fire = 1; tick(); ev_fire = 0; ev_hit = 1; tick(); ev_hit = 0;
    check("t2_level_c12", queue_level, 1);
    go_to(b + 50);
    check("t2_fire_cycle", last_cyc[0], b + 12);
    check("t2_hit_cycle", last_cyc[1], b + 36);
    check("t2_max_level", max_level, 1);
    check("t2_trig_total", total_trigs(), 2);

    // Test 3: six hits back to back, the sixth overflows
    do_reset();
    go_to(b + 10); ev_hit = 1;
    for (int i = 0; i < 6; i++) tick();
    ev_hit = 0;
    check("t3_drops_c16", drop_count, 1);
    check("t3_level_c16", queue_level, 4);
    go_to(b + 100);
    check("t3_hit_count", n_trig[1], 5);
    check("t3_last_hit", last_cyc[1], b + 68);
    check("t3_max_level", max_level, 4);
    check("t3_busy_end", busy, 0);

    // Test 4: fire and explode together, explode wins
    do_reset();
    go_to(b + 10); ev_fire = 1; ev_explode = 1; tick(); ev_fire = 0; ev_explode = 0;
    check("t4_drops", drop_count, 1);
    go_to(b + 12);
    check("t4_trig_explode", trig_explode, 1);
    go_to(b + 60);
    check("t4_fire_count", n_trig[0], 0);
    check("t4_explode_count", n_trig[2], 1);

    // Test 5: game over pre-empts a held sound with entries queued
    do_reset();
    go_to(b + 10); ev_fire = 1; tick(); ev_fire = 0; ev_hit = 1; tick();
    ev_hit = 0; ev_explode = 1; tick(); ev_explode = 0;
    check("t5_level_c13", queue_level, 2);
    go_to(b + 20); ev_gameover = 1; tick(); ev_gameover = 0;
    check("t5_trig_go_c21", trig_gameover, 1);
    check("t5_level_c21", queue_level, 0);
    check("t5_drops_c21", drop_count, 0);
    go_to(b + 30); ev_gameover = 1; tick(); ev_gameover = 0; ev_hit = 1; tick(); ev_hit = 0;
    check("t5_go_count_repeat", n_trig[3], 1);
    check("t5_drops_hit_during_go", drop_count, 1);
    go_to(b + 63);
    check("t5_busy_c63", busy, 1);
    go_to(b + 64);
    check("t5_busy_c64", busy, 0);
    go_to(b + 80);
    check("t5_trig_total", total_trigs(), 2);
    check("t5_hit_count", n_trig[1], 0);
    check("t5_explode_count", n_trig[2], 0);

    // Test 6: reset in the middle of HOLD with two entries queued
    do_reset();
    go_to(b + 10); ev_fire = 1; tick(); ev_fire = 0; ev_hit = 1; tick();
    ev_hit = 0; ev_explode = 1; tick(); ev_explode = 0;
    go_to(b + 20); reset = 1; tick(); reset = 0;
    check("t6_level_after_reset", queue_level, 0);
    check("t6_busy_after_reset", busy, 0);
    check("t6_trigs_after_reset", {28'd0, trig_gameover, trig_explode, trig_hit, trig_fire}, 32'd0);
    snap = total_trigs();
    go_to(b + 80);
    check("t6_no_trigs_after_reset", total_trigs(), snap);
    ev_fire = 1; tick(); ev_fire = 0;
    go_to(b + 83);
    check("t6_new_fire_cycle", last_cyc[0], b + 82);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
